// File: rtl/mem_responder.sv
// Handshaked word memory with fixed response latency and byte-masked writes.
// Ports: clk/reset, req_* (valid/ready request), rsp_* (valid/ready response).
module mem_responder #(
  parameter int ADDR_W  = 13,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [3:0]        req_wmask,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        in_range;
  logic [IDX_W-1:0] idx;

  // First state of a freshly accepted request.
  localparam state_t S_FIRST = (LATENCY > 1) ? S_WAIT : S_RESP;

  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign idx      = req_addr[IDX_W-1:0];
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_FIRST;
          cnt_n   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_n = S_RESP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          // A new request can be taken on the response edge.
          if (accept) begin
            state_n = S_FIRST;
            cnt_n   = LAT_M1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    rsp_valid = (state == S_RESP);
    req_ready = !reset &&
                ((state == S_IDLE) ||
                 ((state == S_RESP) && rsp_ready));
    rsp_rdata = rsp_valid ? rdata_q : '0;
    rsp_err   = rsp_valid && err_q;
  end

  // Array has no reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wmask[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance, so later writes cannot alter it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= !in_range;
      rdata_q <= (in_range && !req_we) ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word-array reference model.
// Checks latency, data, masking, backpressure, back-to-back, errors, reset.
module tb_mem_responder;

  localparam int AW  = 13;
  localparam int DEP = 4096;
  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [3:0]    req_wmask;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  mem_responder #(
    .ADDR_W (AW),
    .DEPTH  (DEP),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_we   (req_we),
    .req_wmask(req_wmask),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [31:0] mdl [DEP];
  logic [31:0] exp_rdata;
  logic        exp_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request, wait for acceptance, update the model.
  task automatic issue(input logic [AW-1:0] a,
                       input logic we,
                       input logic [3:0] m,
                       input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wmask = m;
    req_wdata = d;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    exp_err   = (int'(a) >= DEP);
    exp_rdata = 32'd0;
    if (!exp_err && !we) exp_rdata = mdl[a[11:0]];
    if (!exp_err && we) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) mdl[a[11:0]][8*i +: 8] = d[8*i +: 8];
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_we    = 1'($urandom);
    req_wmask = 4'($urandom);
    req_wdata = $urandom;
  endtask

  // Wait for the response, hold it off for `hold` cycles, then take it.
  task automatic collect(input int hold);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
    chk("latency", 32'(lat), 32'(LAT));
    chk("rdata", rsp_rdata, exp_rdata);
    chk("err", 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, exp_rdata);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("comb_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rdata", rsp_rdata, 32'd0);
    chk("idle_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic [AW-1:0] a,
                      input logic we,
                      input logic [3:0] m,
                      input logic [31:0] d,
                      input int hold);
    issue(a, we, m, d);
    collect(hold);
  endtask

  logic [31:0] expq [$];
  logic        acc;
  int          nreq;
  int          nrsp;
  int          last;
  int          n;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wmask = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Write then read.
    xact(13'h005, 1'b1, 4'hF, 32'hDEADBEEF, 0);
    xact(13'h005, 1'b0, 4'h0, 32'h0, 0);
    chk("wr_rd_model", mdl[5], 32'hDEADBEEF);

    // Byte mask.
    xact(13'h010, 1'b1, 4'hF, 32'h11223344, 0);
    xact(13'h010, 1'b1, 4'b0101, 32'hAABBCCDD, 0);
    xact(13'h010, 1'b0, 4'h0, 32'h0, 0);
    chk("mask_model", mdl[16], 32'h11BB33DD);
    xact(13'h010, 1'b1, 4'h0, 32'hFFFFFFFF, 1);
    xact(13'h010, 1'b0, 4'h0, 32'h0, 0);

    // Backpressure.
    xact(13'h005, 1'b0, 4'h0, 32'h0, 5);

    // Back-to-back reads of 1, 2, 3.
    xact(13'h001, 1'b1, 4'hF, 32'hA, 0);
    xact(13'h002, 1'b1, 4'hF, 32'hB, 0);
    xact(13'h003, 1'b1, 4'hF, 32'hC, 0);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_we    = 1'b0;
    req_addr  = 13'h001;
    req_valid = 1'b1;
    nreq = 0;
    nrsp = 0;
    last = 0;
    for (int t = 0; t < 60 && nrsp < 3; t++) begin
      #1;
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected", 32'd1, 32'd0);
        end else begin
          chk("b2b_rdata", rsp_rdata, expq.pop_front());
        end
        if (nrsp > 0) chk("b2b_gap", 32'(t - last), 32'(LAT));
        last = t;
        nrsp++;
      end
      acc = req_valid && req_ready;
      if (acc) expq.push_back(mdl[req_addr[11:0]]);
      @(posedge clk);
      #1;
      if (acc) begin
        nreq++;
        if (nreq < 3) req_addr = AW'(nreq + 1);
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(nrsp), 32'd3);
    rsp_ready = 1'b0;
    expq.delete();

    // Error path.
    xact(13'h0FFF, 1'b1, 4'hF, 32'h5A5A0FFF, 0);
    xact(13'h1000, 1'b0, 4'h0, 32'h0, 0);
    xact(13'h1FFF, 1'b1, 4'hF, 32'h0BADBAD0, 2);
    xact(13'h0FFF, 1'b0, 4'h0, 32'h0, 0);

    // Reset while waiting on a write.
    issue(13'h020, 1'b1, 4'hF, 32'h12345678);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(req_ready), 32'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("rst_no_reissue", 32'(n), 32'd0);

    // Reset while a response is presented.
    issue(13'h020, 1'b0, 4'h0, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
    chk("rst_resp_seen", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_resp_drop", 32'(rsp_valid), 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_resp_ready", 32'(req_ready), 32'd1);
    xact(13'h020, 1'b0, 4'h0, 32'h0, 0);
    chk("rst_write_kept", mdl[32], 32'h12345678);

    // Randomised traffic over a preloaded window.
    for (int i = 0; i < 32; i++)
      xact(AW'(i), 1'b1, 4'hF, $urandom, 0);
    for (int i = 0; i < 80; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(4096, 8191));
      else a = AW'($urandom_range(0, 31));
      xact(a, 1'($urandom), 4'($urandom), $urandom,
           int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
